// File: rtl/alu.sv
// 16-bit registered ALU: primary/secondary results and a persistent flag register.
// Every operation lands on the rising edge of clk, so results appear one cycle after the inputs.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic [15:0] operand_1,
  input  logic [15:0] operand_2,
  input  logic [3:0]  bit_position,
  output logic [15:0] result_0,
  output logic [15:0] result_1,
  output logic [15:0] flag_reg
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_MUL  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_NOT  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_XOR  = 5'b00111;
  localparam logic [4:0] OP_INC  = 5'b01000;
  localparam logic [4:0] OP_CMP  = 5'b01001;
  localparam logic [4:0] OP_RR   = 5'b01010;
  localparam logic [4:0] OP_RL   = 5'b01011;
  localparam logic [4:0] OP_SETB = 5'b01100;
  localparam logic [4:0] OP_CLRB = 5'b01101;
  localparam logic [4:0] OP_SETF = 5'b01110;
  localparam logic [4:0] OP_SWAP = 5'b01111;

  localparam int FL_C = 0;
  localparam int FL_V = 1;
  localparam int FL_G = 2;
  localparam int FL_E = 3;
  localparam int FL_N = 6;
  localparam int FL_Z = 7;

  logic [16:0] sum, diff, inc;
  logic [31:0] prod;
  logic [15:0] bit_mask;
  logic        add_ovf, sub_ovf;
  logic [15:0] r0_next, r1_next, flags_next;
  logic        update_zn;

  assign sum      = {1'b0, operand_1} + {1'b0, operand_2};
  assign diff     = {1'b0, operand_1} - {1'b0, operand_2};
  assign inc      = {1'b0, operand_1} + 17'd1;
  assign prod     = operand_1 * operand_2;
  assign bit_mask = 16'h0001 << bit_position;
  assign add_ovf  = (operand_1[15] == operand_2[15]) && (sum[15] != operand_1[15]);
  assign sub_ovf  = (operand_1[15] != operand_2[15]) && (diff[15] != operand_1[15]);

  always_comb begin
    r0_next    = '0;
    r1_next    = '0;
    flags_next = flag_reg;
    update_zn  = 1'b0;
    case (opcode)
      OP_ADD: begin
        r0_next = sum[15:0];
        r1_next = {15'b0, sum[16]};
        flags_next[FL_C] = sum[16];
        flags_next[FL_V] = add_ovf;
        update_zn = 1'b1;
      end
      OP_MUL: begin
        r0_next = prod[15:0];
        r1_next = prod[31:16];
        flags_next[FL_C] = (prod[31:16] != 16'h0000);
        flags_next[FL_V] = 1'b0;
        update_zn = 1'b1;
      end
      OP_SUB: begin
        r0_next = diff[15:0];
        r1_next = {15'b0, diff[16]};
        flags_next[FL_C] = diff[16];
        flags_next[FL_V] = sub_ovf;
        update_zn = 1'b1;
      end
      OP_DIV: begin
        // Divide-by-zero saturates the quotient and hands the dividend back as remainder.
        if (operand_2 == 16'h0000) begin
          r0_next = 16'hFFFF;
          r1_next = operand_1;
          flags_next[FL_V] = 1'b1;
        end else begin
          r0_next = operand_1 / operand_2;
          r1_next = operand_1 % operand_2;
          flags_next[FL_V] = 1'b0;
        end
        flags_next[FL_C] = 1'b0;
        update_zn = 1'b1;
      end
      OP_NOT, OP_AND, OP_OR, OP_XOR: begin
        case (opcode)
          OP_NOT:  r0_next = ~operand_1;
          OP_AND:  r0_next = operand_1 & operand_2;
          OP_OR:   r0_next = operand_1 | operand_2;
          default: r0_next = operand_1 ^ operand_2;
        endcase
        flags_next[FL_C] = 1'b0;
        flags_next[FL_V] = 1'b0;
        update_zn = 1'b1;
      end
      OP_INC: begin
        r0_next = inc[15:0];
        r1_next = {15'b0, inc[16]};
        flags_next[FL_C] = inc[16];
        flags_next[FL_V] = (operand_1 == 16'h7FFF);
        update_zn = 1'b1;
      end
      OP_CMP: begin
        // Z tracks E here, which coincides with the difference being zero.
        r0_next = diff[15:0];
        flags_next[FL_E] = (operand_1 == operand_2);
        flags_next[FL_G] = (operand_1 > operand_2);
        flags_next[FL_C] = diff[16];
        flags_next[FL_V] = sub_ovf;
        update_zn = 1'b1;
      end
      OP_RR: begin
        r0_next = {operand_1[0], operand_1[15:1]};
        flags_next[FL_C] = operand_1[0];
        update_zn = 1'b1;
      end
      OP_RL: begin
        r0_next = {operand_1[14:0], operand_1[15]};
        flags_next[FL_C] = operand_1[15];
        update_zn = 1'b1;
      end
      OP_SETB: begin
        r0_next = operand_1 | bit_mask;
        update_zn = 1'b1;
      end
      OP_CLRB: begin
        r0_next = operand_1 & ~bit_mask;
        update_zn = 1'b1;
      end
      OP_SETF: flags_next = flag_reg | bit_mask;
      OP_SWAP: begin
        r0_next = {operand_1[7:0], operand_1[15:8]};
        update_zn = 1'b1;
      end
      default: ;
    endcase
    if (update_zn) begin
      flags_next[FL_Z] = (r0_next == 16'h0000);
      flags_next[FL_N] = r0_next[15];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_0 <= '0;
      result_1 <= '0;
      flag_reg <= '0;
    end else begin
      result_0 <= r0_next;
      result_1 <= r1_next;
      flag_reg <= flags_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: a behavioural model pushes expected results on drive,
// and they are popped and compared one edge later.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic [15:0] operand_1, operand_2;
  logic [3:0]  bit_position;
  logic [15:0] result_0, result_1, flag_reg;

  typedef struct {
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] fl;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_flags;
  logic [15:0] last_r0;
  int          n_vec = 0;
  int          n_err = 0;

  alu dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .operand_1(operand_1), .operand_2(operand_2), .bit_position(bit_position),
    .result_0(result_0), .result_1(result_1), .flag_reg(flag_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference written from the arithmetic definitions using wide integers.
  task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] bp, output logic [15:0] r0, output logic [15:0] r1);
    int unsigned ua, ub, wide;
    int          sa, sb, sres;
    longint unsigned p;
    logic zn;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r0 = 16'h0; r1 = 16'h0; zn = 1'b1;
    case (op)
      5'd0: begin
        wide = ua + ub; r0 = wide[15:0]; r1 = (wide > 65535) ? 16'd1 : 16'd0;
        sres = sa + sb;
        m_flags[0] = (wide > 65535); m_flags[1] = (sres > 32767 || sres < -32768);
      end
      5'd1: begin
        p = longint'(ua) * longint'(ub); r0 = p[15:0]; r1 = p[31:16];
        m_flags[0] = (p >= 65536); m_flags[1] = 1'b0;
      end
      5'd2: begin
        wide = ua - ub; r0 = wide[15:0]; r1 = (ua < ub) ? 16'd1 : 16'd0;
        sres = sa - sb;
        m_flags[0] = (ua < ub); m_flags[1] = (sres > 32767 || sres < -32768);
      end
      5'd3: begin
        if (ub == 0) begin r0 = 16'hFFFF; r1 = a; m_flags[1] = 1'b1; end
        else begin wide = ua / ub; r0 = wide[15:0]; wide = ua % ub; r1 = wide[15:0]; m_flags[1] = 1'b0; end
        m_flags[0] = 1'b0;
      end
      5'd4, 5'd5, 5'd6, 5'd7: begin
        for (int i = 0; i < 16; i++)
          case (op)
            5'd4: r0[i] = !a[i];
            5'd5: r0[i] = a[i] && b[i];
            5'd6: r0[i] = a[i] || b[i];
            default: r0[i] = a[i] != b[i];
          endcase
        m_flags[0] = 1'b0; m_flags[1] = 1'b0;
      end
      5'd8: begin
        wide = ua + 1; r0 = wide[15:0]; r1 = (ua == 65535) ? 16'd1 : 16'd0;
        m_flags[0] = (ua == 65535); m_flags[1] = (ua == 32767);
      end
      5'd9: begin
        wide = ua - ub; r0 = wide[15:0]; sres = sa - sb;
        m_flags[3] = (ua == ub); m_flags[2] = (ua > ub); m_flags[0] = (ua < ub);
        m_flags[1] = (sres > 32767 || sres < -32768);
      end
      5'd10: begin wide = (ua >> 1) | ((ua & 1) << 15); r0 = wide[15:0]; m_flags[0] = a[0]; end
      5'd11: begin wide = (ua << 1) | (ua >> 15); r0 = wide[15:0]; m_flags[0] = a[15]; end
      5'd12: begin r0 = a; r0[bp] = 1'b1; end
      5'd13: begin r0 = a; r0[bp] = 1'b0; end
      5'd14: begin m_flags[bp] = 1'b1; zn = 1'b0; end
      5'd15: begin wide = ((ua & 255) << 8) | (ua >> 8); r0 = wide[15:0]; end
      default: zn = 1'b0;
    endcase
    if (zn) begin m_flags[7] = (r0 == 16'h0); m_flags[6] = r0[15]; end
  endtask

  task automatic apply(input logic rst, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] bp);
    exp_t e, got;
    @(negedge clk);
    rst_n = rst; opcode = op; operand_1 = a; operand_2 = b; bit_position = bp;
    if (!rst) begin
      m_flags = 16'h0; e.r0 = 16'h0; e.r1 = 16'h0;
    end else begin
      model(op, a, b, bp, e.r0, e.r1);
    end
    e.fl = m_flags;
    sb_q.push_back(e);
    #1 chk("hold_r0", result_0, last_r0);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk($sformatf("op%0d_r0", op), result_0, got.r0);
    chk($sformatf("op%0d_r1", op), result_1, got.r1);
    chk($sformatf("op%0d_flags", op), flag_reg, got.fl);
    last_r0 = got.r0;
  endtask

  initial begin
    m_flags = 16'h0; last_r0 = 16'h0;
    rst_n = 1'b0; opcode = '0; operand_1 = '0; operand_2 = '0; bit_position = '0;
    @(posedge clk); #1;
    last_r0 = result_0;
    apply(1'b0, 5'd0, 16'h1234, 16'h5678, 4'd0);
    chk("reset_r0", result_0, 16'h0000);
    chk("reset_flags", flag_reg, 16'h0000);

    apply(1'b1, 5'd14, 16'h0, 16'h0, 4'd0);
    apply(1'b1, 5'd14, 16'h0, 16'h0, 4'd7);
    apply(1'b1, 5'd14, 16'h0, 16'h0, 4'd6);
    apply(1'b1, 5'd14, 16'h0, 16'h0, 4'd4);
    chk("setf_cumulative", flag_reg, 16'h00D1);
    apply(1'b1, 5'd14, 16'h0, 16'h0, 4'd15);
    apply(1'b1, 5'd20, 16'hFFFF, 16'hFFFF, 4'd3);
    chk("reserved_keeps_flags", flag_reg, 16'h80D1);

    apply(1'b1, 5'd0, 16'd10, 16'd20, 4'd0);     chk("add_small", result_0, 16'h001E);
    apply(1'b1, 5'd0, 16'hFFFF, 16'h0001, 4'd0); chk("add_carry_r1", result_1, 16'h0001);
    chk("add_carry_cz", flag_reg[7] & flag_reg[0], 1'b1);
    apply(1'b1, 5'd0, 16'h7FFF, 16'h7FFF, 4'd0); chk("add_ovf", result_0, 16'hFFFE);
    chk("add_vn", {flag_reg[6], flag_reg[1]}, 2'b11);
    apply(1'b1, 5'd1, 16'hFFFF, 16'h0002, 4'd0); chk("mul_hi", result_1, 16'h0001);
    apply(1'b1, 5'd2, 16'd40, 16'd29, 4'd0);     chk("sub", result_0, 16'h000B);
    apply(1'b1, 5'd3, 16'd20, 16'd5, 4'd0);      chk("div", result_0, 16'h0004);
    apply(1'b1, 5'd3, 16'd20, 16'd0, 4'd0);      chk("div0_r1", result_1, 16'h0014);
    chk("div0_v", flag_reg[1], 1'b1);
    apply(1'b1, 5'd4, 16'hAAAA, 16'h0, 4'd0);    chk("not", result_0, 16'h5555);
    apply(1'b1, 5'd5, 16'hAAAA, 16'h5555, 4'd0);
    apply(1'b1, 5'd6, 16'hAAAA, 16'h5555, 4'd0); chk("or", result_0, 16'hFFFF);
    apply(1'b1, 5'd7, 16'hAAAA, 16'h5555, 4'd0);
    apply(1'b1, 5'd8, 16'd10, 16'h0, 4'd0);      chk("inc", result_0, 16'h000B);
    apply(1'b1, 5'd8, 16'hFFFF, 16'h0, 4'd0);
    apply(1'b1, 5'd8, 16'h7FFF, 16'h0, 4'd0);
    apply(1'b1, 5'd9, 16'd10, 16'd10, 4'd0);     chk("cmp_eq", {flag_reg[7], flag_reg[3]}, 2'b11);
    apply(1'b1, 5'd9, 16'd20, 16'd10, 4'd0);     chk("cmp_gt", {flag_reg[3], flag_reg[2]}, 2'b01);
    apply(1'b1, 5'd9, 16'd10, 16'd20, 4'd0);     chk("cmp_lt", {flag_reg[2], flag_reg[0]}, 2'b01);
    apply(1'b1, 5'd10, 16'hAAAA, 16'h0, 4'd0);   chk("rr", result_0, 16'h5555);
    apply(1'b1, 5'd11, 16'hAAAA, 16'h0, 4'd0);   chk("rl_c", flag_reg[0], 1'b1);
    apply(1'b1, 5'd12, 16'h0000, 16'h0, 4'd8);   chk("setb", result_0, 16'h0100);
    apply(1'b1, 5'd13, 16'hFFFF, 16'h0, 4'd8);   chk("clrb", result_0, 16'hFEFF);
    apply(1'b1, 5'd15, 16'hABCD, 16'h0, 4'd0);   chk("swap", result_0, 16'hCDAB);
    apply(1'b1, 5'd15, 16'h0000, 16'h0, 4'd0);

    for (int i = 0; i < 300; i++)
      apply(1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            4'($urandom));
    apply(1'b0, 5'd14, 16'h0, 16'h0, 4'd9);
    apply(1'b1, 5'd14, 16'h0, 16'h0, 4'd9);

    if (sb_q.size() != 0) chk("scoreboard_empty", 16'(sb_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
